// File: rtl/debounce_sync.sv
// debounce_sync: synchronizes a raw, possibly bouncing level and only lets
// the output q follow it once it has held steady for STABLE_CYCLES
// consecutive synchronized samples.
// Optional feature macro: DEBOUNCE_EDGE_EN. It enables the registered
// rise/fall pulse outputs. When it is undefined, rise/fall are tied to 0.
module debounce_sync #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 8,
  parameter int CNT_W         = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } state_t;

  // The last count value before a candidate level is accepted. Because the
  // counter is cleared on acceptance, it never goes past this value.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   d_sync;
  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic                   q_reg, q_next;

  assign d_sync = sync_reg[SYNC_STAGES-1];

  // Plain flop chain: d shifts in at bit 0, and nothing sits between stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_reg <= '0;
    else     sync_reg <= {sync_reg[SYNC_STAGES-2:0], d};
  end

  // FSM state, stability counter and the registered output level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= STABLE_LO;
      cnt_reg   <= '0;
      q_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      q_reg     <= q_next;
    end
  end

  // Next-state logic. Any sample that matches the current level during a
  // check aborts that check. q is decoded from the next state, so it changes
  // on the same edge that the candidate level is accepted.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      STABLE_LO: begin
        if (d_sync) begin
          state_next = CHK_HI;
          cnt_next   = CNT_ONE;
        end else begin
          cnt_next = '0;
        end
      end
      CHK_HI: begin
        if (!d_sync) begin
          state_next = STABLE_LO;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = STABLE_HI;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!d_sync) begin
          state_next = CHK_LO;
          cnt_next   = CNT_ONE;
        end else begin
          cnt_next = '0;
        end
      end
      CHK_LO: begin
        if (d_sync) begin
          state_next = STABLE_HI;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = STABLE_LO;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = STABLE_LO;
        cnt_next   = '0;
      end
    endcase
    q_next = (state_next == STABLE_HI) || (state_next == CHK_LO);
  end

  assign q = q_reg;

`ifdef DEBOUNCE_EDGE_EN
  logic rise_reg, fall_reg;

  // Edge pulses register together with q, so each pulse lines up with the
  // first cycle in which q shows its new value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      rise_reg <= q_next & ~q_reg;
      fall_reg <= ~q_next & q_reg;
    end
  end

  assign rise = rise_reg;
  assign fall = fall_reg;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule
